// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: 4-digit multiplexed common-anode 7-seg driver with leading-zero blanking and per-frame capture; `define SSEG_LAMP_TEST_EN adds a lamp_test input
module sseg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
`ifdef SSEG_LAMP_TEST_EN
    input  logic       lamp_test,
`endif
    input  logic [3:0] thousands,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    logic [CW-1:0] cnt;
    logic [1:0] idx;
    logic [3:0][3:0] sh;
    logic [3:0] lz;
    logic [3:0] cur;
    logic [6:0] dec;
    logic [3:0] an_nxt;
    logic [6:0] seg_nxt;
    logic dp_nxt;
    logic wrap;
    logic lamp;
    logic blank;
`ifdef SSEG_LAMP_TEST_EN
    assign lamp = lamp_test;
`else
    assign lamp = 1'b0;
`endif
    assign wrap = cnt == CW'(REFRESH_DIV - 1);
    assign cur = sh[idx];
    // a digit is a leading zero only if every more-significant digit is too
    assign lz[3] = sh[3] == 4'd0;
    assign lz[2] = lz[3] && sh[2] == 4'd0;
    assign lz[1] = lz[2] && sh[1] == 4'd0;
    assign lz[0] = 1'b0;
    assign blank = !lamp && lz[idx];
    always_comb begin
        case (cur)
            4'd0: dec = 7'b1000000;
            4'd1: dec = 7'b1111001;
            4'd2: dec = 7'b0100100;
            4'd3: dec = 7'b0110000;
            4'd4: dec = 7'b0011001;
            4'd5: dec = 7'b0010010;
            4'd6: dec = 7'b0000010;
            4'd7: dec = 7'b1111000;
            4'd8: dec = 7'b0000000;
            4'd9: dec = 7'b0010000;
            default: dec = 7'b0111111;
        endcase
    end
    always_comb begin
        an_nxt = (cnt < CW'(BLANK_CYC) || blank) ? 4'hF : ~(4'b0001 << idx);
        seg_nxt = lamp ? 7'h00 : blank ? 7'h7F : dec;
        dp_nxt = !lamp;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
            sh <= '0;
            an <= 4'hF;
            seg <= 7'h7F;
            dp <= 1'b1;
        end else begin
            cnt <= wrap ? '0 : cnt + CW'(1);
            if (wrap) idx <= idx + 2'd1;
            if (wrap && idx == 2'd3) sh <= {thousands, hundreds, tens, ones};
            an <= an_nxt;
            seg <= seg_nxt;
            dp <= dp_nxt;
        end
    end
endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver: directed scan checks with REFRESH_DIV=4, BLANK_CYC=1 (16-clock frames)
module tb_sseg_scan_driver;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
    localparam logic [6:0] SD = 7'b0111111, SB = 7'b1111111;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [3:0] thousands = '0, hundreds = '0, tens = '0, ones = '0;
`ifdef SSEG_LAMP_TEST_EN
    logic lamp_test = 1'b0;
`endif
    logic [3:0] an;
    logic [6:0] seg;
    logic dp;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    sseg_scan_driver #(.REFRESH_DIV(4), .BLANK_CYC(1)) dut (
        .clk(clk),
        .rst(rst),
`ifdef SSEG_LAMP_TEST_EN
        .lamp_test(lamp_test),
`endif
        .thousands(thousands),
        .hundreds(hundreds),
        .tens(tens),
        .ones(ones),
        .an(an),
        .seg(seg),
        .dp(dp)
    );
    task automatic chk(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        checks++;
        assert (an === ea) else begin errors++; $error("FAIL %s an=%b expected %b", tag, an, ea); end
        checks++;
        assert (seg === es) else begin errors++; $error("FAIL %s seg=%b expected %b", tag, seg, es); end
        checks++;
        assert (dp === ed) else begin errors++; $error("FAIL %s dp=%b expected %b", tag, dp, ed); end
    endtask
    task automatic step(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        @(posedge clk);
        #1;
        chk(tag, ea, es, ed);
    endtask
    // one digit slot: blank cycle with anodes off, then three lit cycles
    task automatic slot(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        step(tag, 4'hF, es, ed);
        repeat (3) step(tag, ea, es, ed);
    endtask
    task automatic set(input logic [3:0] t, input logic [3:0] h, input logic [3:0] te, input logic [3:0] o);
        thousands = t;
        hundreds = h;
        tens = te;
        ones = o;
    endtask
    initial begin
        set(1, 2, 3, 4);
        repeat (3) @(posedge clk);
        #1;
        chk("reset", 4'hF, SB, 1'b1);
        @(negedge clk) rst = 1'b1;
        slot("f1_ones", 4'b1110, S0, 1'b1);
        repeat (3) slot("f1_lz", 4'hF, SB, 1'b1);
        slot("scan_ones", 4'b1110, S4, 1'b1);
        slot("scan_tens", 4'b1101, S3, 1'b1);
        slot("scan_hund", 4'b1011, S2, 1'b1);
        slot("scan_thou", 4'b0111, S1, 1'b1);
        slot("scan2_ones", 4'b1110, S4, 1'b1);
        step("scan2_tens", 4'hF, S3, 1'b1);
        step("scan2_tens", 4'b1101, S3, 1'b1);
        #2 rst = 1'b0;
        #1 chk("async_reset", 4'hF, SB, 1'b1);
        set(0, 0, 7, 2);
        @(negedge clk) rst = 1'b1;
        slot("rst_ones", 4'b1110, S0, 1'b1);
        repeat (3) slot("rst_lz", 4'hF, SB, 1'b1);
        slot("lz_ones", 4'b1110, S2, 1'b1);
        set(0, 0, 6, 0);
        slot("lz_tens", 4'b1101, S7, 1'b1);
        slot("lz_hund", 4'hF, SB, 1'b1);
        slot("lz_thou", 4'hF, SB, 1'b1);
        slot("tear_ones", 4'b1110, S0, 1'b1);
        step("tear_tens", 4'hF, S6, 1'b1);
        step("tear_tens", 4'b1101, S6, 1'b1);
        set(0, 1, 2, 3);
        repeat (2) step("tear_tens", 4'b1101, S6, 1'b1);
        slot("tear_hund", 4'hF, SB, 1'b1);
        slot("tear_thou", 4'hF, SB, 1'b1);
        slot("new_ones", 4'b1110, S3, 1'b1);
        set(0, 0, 0, 4'hC);
        slot("new_tens", 4'b1101, S2, 1'b1);
        slot("new_hund", 4'b1011, S1, 1'b1);
        slot("new_thou", 4'hF, SB, 1'b1);
        slot("bad_ones", 4'b1110, SD, 1'b1);
        set(0, 0, 0, 0);
        repeat (3) slot("bad_lz", 4'hF, SB, 1'b1);
        slot("zero_ones", 4'b1110, S0, 1'b1);
`ifdef SSEG_LAMP_TEST_EN
        set(0, 0, 0, 5);
`endif
        repeat (3) slot("zero_lz", 4'hF, SB, 1'b1);
`ifdef SSEG_LAMP_TEST_EN
        lamp_test = 1'b1;
        slot("lamp_ones", 4'b1110, 7'h00, 1'b0);
        slot("lamp_tens", 4'b1101, 7'h00, 1'b0);
        slot("lamp_hund", 4'b1011, 7'h00, 1'b0);
        slot("lamp_thou", 4'b0111, 7'h00, 1'b0);
        lamp_test = 1'b0;
        slot("lamp_off_ones", 4'b1110, S5, 1'b1);
        repeat (3) slot("lamp_off_lz", 4'hF, SB, 1'b1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Downstream consumer of heart_rate_top. Takes its four BCD digit outputs (thousands, hundreds, tens, ones) and drives a 4-digit common-anode seven-segment display.
- Time-multiplexes the four digits with a refresh divider and inserts a short anti-ghosting blank at the start of each digit slot.
- Blanks leading zeros and captures digit values once per scan frame, so a BCD update mid-frame never tears the display.

Parameters:
- REFRESH_DIV, 100000: clocks per digit slot; must be >= 2.
- BLANK_CYC, 2: clocks at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- thousands  in  4  BCD digit 3 from heart_rate_top.
- hundreds  in  4  BCD digit 2.
- tens  in  4  BCD digit 1.
- ones  in  4  BCD digit 0.
- an  out  4  anode enables, active-low; an[0] = ones position.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; held 1 (off) in normal operation.

Behaviour:
- Reset (rst=0, asynchronous, effective immediately, no clock needed):
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Refresh counter cnt=0, digit index idx=0, all four shadow digit registers=0.
- Refresh counter cnt:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On the wrap, idx advances 0→1→2→3→0.
  - idx 0=ones, 1=tens, 2=hundreds, 3=thousands.
  - Frame length is 4*REFRESH_DIV clocks.
- Frame capture:
  - When cnt==REFRESH_DIV-1 and idx==3, all four inputs are latched into the shadow registers on the same edge that idx returns to 0.
  - Input changes at any other time are ignored until the next frame boundary.
  - The first capture after reset release happens at the end of the first frame. Until then the shadow values are 0, so only the ones digit shows "0".
- Output registration:
  - an, seg and dp are registered.
  - Values at cycle t+1 are a function of cnt, idx and shadow at cycle t, giving 1-cycle latency.
- Anode selection:
  - If cnt < BLANK_CYC: an=4'b1111.
  - Else if the selected digit is blanked: an=4'b1111.
  - Else: an = ~(4'b0001 << idx).
- Leading-zero blanking, applied to shadow values:
  - Digit 3 is blanked if it is 0.
  - Digit 2 is blanked if digits 3 and 2 are both 0.
  - Digit 1 is blanked if digits 3, 2 and 1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit also forces seg=7'b1111111.
- Segment decode:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Non-BCD values 10–15 decode as a dash, 0111111 (segment g only).
  - A non-BCD value counts as non-zero for blanking purposes.
- During the blank interval seg still carries the decoded value for the upcoming digit; only an is forced off.
- Reset asserted mid-frame aborts the scan. After release, scanning restarts at idx=0, cnt=0.

Optional Feature:
- Macro: SSEG_LAMP_TEST_EN.
- When defined:
  - Adds input lamp_test (1 bit, active-high).
  - While lamp_test=1, seg=7'b0000000 and dp=0 for every slot, and leading-zero blanking is suppressed, so all four anodes cycle.
  - The BLANK_CYC interval, refresh timing and frame capture are unchanged.
  - Takes effect with the same 1-cycle latency.
- When undefined:
  - The port does not exist and dp is constant 1 after reset.

Test Plan:
- Reset: REFRESH_DIV=4, BLANK_CYC=1; drive rst=0 mid-slot with an=4'b1101 → an=1111, seg=1111111, dp=1 before the next clock edge; after release, first lit an=1110 with seg=1000000 (shadow 0).
- Full scan: inputs 1,2,3,4 (thousands..ones), wait one full frame (16 clocks) → repeating an pattern 1111,1110×3; 1111,1101×3; 1111,1011×3; 1111,0111×3. Paired seg values: 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1).
- Leading-zero blanking:
  - Inputs 0,0,7,2 → slots 2 and 3 show an=1111, seg=1111111; tens shows 1111000; ones shows 0100100.
  - Inputs 0,0,0,0 → only an=1110 lit, seg=1000000.
- Tear-free capture: inputs 0,0,6,0 captured; at the middle of idx=1 change to 0,1,2,3 → rest of the frame still shows 6/0; next frame shows 1/2/3 with thousands blanked.
- Invalid BCD: ones=4'hC, others 0 → an=1110 lit with seg=0111111.
- Lamp test (with SSEG_LAMP_TEST_EN): inputs 0,0,0,5 and lamp_test=1 → all four anodes cycle with seg=0000000, dp=0; lamp_test=0 → normal display of "5" only, dp=1.
